sram2axi_bridge_mo: RTL

//   Multi-outstanding SRAM-like to AXI3 bridge between the CPU inst/data SRAM-like ports and the AXI bus.

---
 rtl/sram2axi_bridge_mo_if.sv | 71 +++++++
 rtl/sram2axi_bridge_mo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sram2axi_bridge_mo_if.sv
// AXI3 bus bundle between the SRAM-like bridge (master) and the interconnect (slave).
interface sram2axi_bridge_mo_if #(
  parameter int DW = 32
);
  logic [3:0]      arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [3:0]      rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [3:0]      awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [3:0]      wid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [3:0]      bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram2axi_bridge_mo.sv
// SRAM-like (inst read-only + data read/write) to AXI3 bridge with multiple outstanding
// transactions; in-order responses per master through fixed IDs (inst=0, data=1).
module sram2axi_bridge_mo #(
  parameter int DW       = 32,
  parameter int RD_DEPTH = 4,
  parameter int WR_DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_sram_req,
  input  logic [31:0]         inst_sram_addr,
  input  logic [1:0]          inst_sram_size,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DW-1:0]       inst_sram_rdata,

  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [31:0]         data_sram_addr,
  input  logic [DW/8-1:0]     data_sram_wstrb,
  input  logic [DW-1:0]       data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DW-1:0]       data_sram_rdata,

  sram2axi_bridge_mo_if.master axi
);
  localparam int SW = DW / 8;
  localparam logic [3:0] RD_MAX = 4'(RD_DEPTH);
  localparam logic [3:0] WR_MAX = 4'(WR_DEPTH);

  logic            ar_valid_reg;
  logic [31:0]     ar_addr_reg;
  logic [3:0]      ar_id_reg;
  logic [2:0]      ar_size_reg;
  logic            aw_valid_reg;
  logic            w_valid_reg;
  logic [31:0]     aw_addr_reg;
  logic [2:0]      aw_size_reg;
  logic [DW-1:0]   w_data_reg;
  logic [SW-1:0]   w_strb_reg;
  logic [3:0]      rcnt_i_reg;
  logic [3:0]      rcnt_d_reg;
  logic [3:0]      wcnt_reg;
  logic            resp_rdy_reg;
  logic            inst_ok_reg;
  logic            data_ok_reg;
  logic [DW-1:0]   inst_rdata_reg;
  logic [DW-1:0]   data_rdata_reg;

  logic ar_free, wr_idle;
  logic d_rd_acc, d_wr_acc, i_acc;
  logic r_hs, r_inst, r_data, b_ok;
  logic unused_resp;

  function automatic logic [3:0] cnt_step(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 4'd1;
    else if (dec && !inc)
      res = cnt - 4'd1;
    return res;
  endfunction

  // A read and a write are never outstanding together on the data port, so its
  // responses cannot overtake each other and reads never see stale memory.
  assign ar_free  = !ar_valid_reg || axi.arready;
  assign wr_idle  = !aw_valid_reg && !w_valid_reg;
  assign d_rd_acc = data_sram_req && !data_sram_wr && ar_free &&
                    (rcnt_d_reg < RD_MAX) && (wcnt_reg == 4'd0);
  assign d_wr_acc = data_sram_req && data_sram_wr && wr_idle &&
                    (wcnt_reg < WR_MAX) && (rcnt_d_reg == 4'd0);
  assign i_acc    = inst_sram_req && ar_free && (rcnt_i_reg < RD_MAX) && !d_rd_acc;

  // Responses arriving with a zero counter are protocol errors and are dropped.
  assign r_hs   = axi.rvalid && resp_rdy_reg;
  assign r_inst = r_hs && (axi.rid == 4'd0) && (rcnt_i_reg != 4'd0);
  assign r_data = r_hs && (axi.rid == 4'd1) && (rcnt_d_reg != 4'd0);
  assign b_ok   = axi.bvalid && resp_rdy_reg && (wcnt_reg != 4'd0);

  assign unused_resp = ^{axi.rresp, axi.rlast, axi.bid, axi.bresp};

  assign inst_sram_addr_ok = i_acc;
  assign inst_sram_data_ok = inst_ok_reg;
  assign inst_sram_rdata   = inst_rdata_reg;
  assign data_sram_addr_ok = d_rd_acc || d_wr_acc;
  assign data_sram_data_ok = data_ok_reg;
  assign data_sram_rdata   = data_rdata_reg;

  assign axi.arid    = ar_id_reg;
  assign axi.araddr  = ar_addr_reg;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = ar_size_reg;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = ar_valid_reg;
  assign axi.rready  = resp_rdy_reg;

  assign axi.awid    = 4'd1;
  assign axi.awaddr  = aw_addr_reg;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = aw_size_reg;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = aw_valid_reg;
  assign axi.wid     = 4'd1;
  assign axi.wdata   = w_data_reg;
  assign axi.wstrb   = w_strb_reg;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_valid_reg;
  assign axi.bready  = resp_rdy_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_reg   <= 1'b0;
      ar_addr_reg    <= '0;
      ar_id_reg      <= '0;
      ar_size_reg    <= '0;
      aw_valid_reg   <= 1'b0;
      w_valid_reg    <= 1'b0;
      aw_addr_reg    <= '0;
      aw_size_reg    <= '0;
      w_data_reg     <= '0;
      w_strb_reg     <= '0;
      rcnt_i_reg     <= '0;
      rcnt_d_reg     <= '0;
      wcnt_reg       <= '0;
      resp_rdy_reg   <= 1'b0;
      inst_ok_reg    <= 1'b0;
      data_ok_reg    <= 1'b0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      resp_rdy_reg <= 1'b1;

      // The AR slot only reloads once the previous address has been taken.
      if (ar_free) begin
        ar_valid_reg <= d_rd_acc || i_acc;
        if (d_rd_acc) begin
          ar_id_reg   <= 4'd1;
          ar_addr_reg <= data_sram_addr;
          ar_size_reg <= {1'b0, data_sram_size};
        end else if (i_acc) begin
          ar_id_reg   <= 4'd0;
          ar_addr_reg <= inst_sram_addr;
          ar_size_reg <= {1'b0, inst_sram_size};
        end
      end

      if (d_wr_acc) begin
        aw_valid_reg <= 1'b1;
        w_valid_reg  <= 1'b1;
        aw_addr_reg  <= data_sram_addr;
        aw_size_reg  <= {1'b0, data_sram_size};
        w_data_reg   <= data_sram_wdata;
        w_strb_reg   <= data_sram_wstrb;
      end else begin
        if (axi.awready) aw_valid_reg <= 1'b0;
        if (axi.wready)  w_valid_reg  <= 1'b0;
      end

      rcnt_i_reg <= cnt_step(rcnt_i_reg, i_acc, r_inst);
      rcnt_d_reg <= cnt_step(rcnt_d_reg, d_rd_acc, r_data);
      wcnt_reg   <= cnt_step(wcnt_reg, d_wr_acc, b_ok);

      inst_ok_reg <= r_inst;
      data_ok_reg <= r_data || b_ok;
      if (r_inst) inst_rdata_reg <= axi.rdata;
      if (r_data) data_rdata_reg <= axi.rdata;
    end
  end
endmodule
